osc_bank_scheduler: RTL and testbench
=====================================

Name: osc_bank_scheduler

Overview:
- Time-multiplexes one shared damped-oscillator update datapath across NUM_OSC oscillator channels.
- Each channel's position, velocity and neutral point live in register arrays. A sweep FSM steps the channels in order, one per cycle.
- A valid/ready config port loads channel state between sweeps.
- Per-channel 8-bit positions are published as a coherent snapshot at the end of each sweep, for the feedback/coupling logic and downstream consumers.

Parameters:
- NUM_OSC, 4: number of oscillator channels (2..16).
- KV_SHIFT, 9: velocity damping, as an arithmetic right shift (2^-9 ≈ 0.002).
- KP_SHIFT, 11: spring constant, as an arithmetic right shift (2^-11 ≈ 0.0005).
- FB_GAIN, 10000: signed integer gain applied to feedback.
- INIT_POS, 429496729: reset position, (2^31-1)/5.
- INIT_NEUTRAL, 1073741824: reset neutral point, 2^30.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-shot sweep request.
- run  in  1  free-running mode; while high, sweeps repeat.
- cfgValid  in  1  config write request.
- cfgReady  out  1  config write accepted this cycle when cfgValid is also high.
- cfgChannel  in  $clog2(NUM_OSC)  target channel.
- cfgSel  in  2  field select: 0 = position, 1 = velocity, 2 = neutral, 3 = reserved (write ignored, handshake still completes).
- cfgData  in  32  signed value to write.
- feedback  in  NUM_OSC*8  signed 8-bit feedback per channel; channel i is bits [8i+7:8i].
- positionOut  out  NUM_OSC*8  snapshot of position[31:24] per channel.
- busy  out  1  high while a sweep is in progress.
- sweepDone  out  1  one-cycle pulse when the snapshot updates.
- sweepCount  out  16  number of completed sweeps; wraps at 65535 -> 0.

Behaviour:
- Reset (async, immediate):
  - All positions = INIT_POS; all velocities = 0; all neutrals = INIT_NEUTRAL.
  - positionOut = INIT_POS[31:24] = 0x19 per channel.
  - busy = 0, sweepDone = 0, sweepCount = 0, FSM = IDLE, channel index = 0.
  - Reset asserted mid-sweep discards partial progress; no snapshot is taken.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when (start | run) and no config write is accepted in the same cycle.
  - SWEEP: one channel per cycle, index 0..NUM_OSC-1; after the last channel -> DONE.
  - DONE (1 cycle): positionOut <= all position[31:24] (post-update values); sweepDone = 1; sweepCount += 1; -> IDLE.
- Sweep latency: start seen in IDLE -> sweepDone high NUM_OSC+1 cycles later. The minimum sweep period under run is NUM_OSC+2 cycles.
- busy = 1 in SWEEP and DONE.
- Per-channel update in SWEEP, channel c, all 32-bit signed:
  - acc = -(vel >>> KV_SHIFT) - ((pos - neutral) >>> KP_SHIFT) + feedback[c] * FB_GAIN.
  - pos <= pos + vel (old vel); vel <= vel + acc.
  - Shifts floor toward -inf.
  - All sums wrap two's-complement; no saturation.
  - feedback[c] is sampled in channel c's SWEEP cycle.
- Config:
  - cfgReady = 1 only in IDLE.
  - A write occurs on cfgValid & cfgReady.
  - A write takes priority over start/run in the same cycle; the sweep starts in the next IDLE cycle if the request is still present.
  - start is a level sampled in IDLE only; a start pulse during SWEEP/DONE is ignored, not queued.
- Config effects: a written position is not reflected on positionOut until the next DONE.
- run deasserted mid-sweep: the current sweep completes; the FSM then stays in IDLE.

Decomposition:
- Package osc_pkg: state enum (IDLE/SWEEP/DONE), cfgSel encodings (CFG_POS/CFG_VEL/CFG_NEUTRAL), 32-bit signed state typedef, reset constants.
- Sub-module osc_step: purely combinational.
  - Inputs: pos, vel, neutral, feedback.
  - Outputs: next pos, next vel.
  - Parameterised by KV_SHIFT, KP_SHIFT, FB_GAIN.
  - One instance, shared via the channel-index mux.

Test Plan:
1. Reset release -> positionOut = 0x19191919 (N=4), busy = 0, cfgReady = 1, sweepCount = 0.
2. Single start pulse, feedback = 0:
   - Response: busy high 5 cycles; sweepDone 5 cycles after start.
   - After sweep 1: every vel = 314573, pos = 429496729.
   - After sweep 2: pos = 429811302.
3. Feedback, config then start:
   - Config writes ch1 pos = 2^30, vel = 0; feedback ch1 = +1, then start.
   - Response: ch1 vel = 10000 after one sweep.
   - Repeat with feedback = -128: ch1 vel = -1280000.
4. Wrap-around:
   - Config ch2 pos = 0x7FFFFFFF, vel = 0x7FFFFFFF; two sweeps.
   - Response: ch2 pos = 0xFFFFFFFE after sweep 1; positionOut[23:16] = 0xFF.
5. Config during sweep:
   - cfgValid held during SWEEP -> cfgReady = 0 until IDLE; the write is accepted in the first IDLE cycle.
   - cfgValid and start together in IDLE -> write wins; SWEEP entered one cycle later.
6. run held for 3 sweeps -> sweepDone pulses spaced 6 cycles apart, sweepCount = 3.
   - Async reset asserted mid-sweep 4 -> all state returns to reset values immediately; no sweepDone pulse.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types, encodings and reset constants for the oscillator bank.
// Imported by the update datapath and the sweep scheduler.
package osc_pkg;

    typedef logic signed [31:0] osc_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        CFG_POS     = 2'd0,
        CFG_VEL     = 2'd1,
        CFG_NEUTRAL = 2'd2,
        CFG_RSVD    = 2'd3
    } cfg_sel_t;

    localparam int DEF_NUM_OSC      = 4;
    localparam int DEF_KV_SHIFT     = 9;
    localparam int DEF_KP_SHIFT     = 11;
    localparam int DEF_FB_GAIN      = 10000;
    localparam int DEF_INIT_POS     = 429496729;
    localparam int DEF_INIT_NEUTRAL = 1073741824;

    function automatic logic [7:0] pos_byte(input osc_word_t w);
        return w[31:24];
    endfunction

endpackage

// File: rtl/osc_step.sv
// Combinational damped-oscillator update for one channel.
// All arithmetic wraps at 32 bits; shifts floor toward -inf.
module osc_step
    import osc_pkg::*;
#(
    parameter int KV_SHIFT = DEF_KV_SHIFT,
    parameter int KP_SHIFT = DEF_KP_SHIFT,
    parameter int FB_GAIN  = DEF_FB_GAIN
) (
    input  osc_word_t         pos,
    input  osc_word_t         vel,
    input  osc_word_t         neutral,
    input  logic signed [7:0] feedback,
    output osc_word_t         pos_next,
    output osc_word_t         vel_next
);

    osc_word_t offset;
    osc_word_t damp;
    osc_word_t spring;
    osc_word_t drive;
    osc_word_t acc;

    always_comb begin
        offset   = pos - neutral;
        damp     = vel >>> KV_SHIFT;
        spring   = offset >>> KP_SHIFT;
        drive    = osc_word_t'(feedback) * osc_word_t'(FB_GAIN);
        acc      = drive - damp - spring;
        pos_next = pos + vel;
        vel_next = vel + acc;
    end

endmodule

// File: rtl/osc_bank_scheduler.sv
// Sweeps a bank of oscillator channels through one shared update step
// and publishes a coherent 8-bit position snapshot after every sweep.
module osc_bank_scheduler
    import osc_pkg::*;
#(
    parameter int NUM_OSC      = DEF_NUM_OSC,
    parameter int KV_SHIFT     = DEF_KV_SHIFT,
    parameter int KP_SHIFT     = DEF_KP_SHIFT,
    parameter int FB_GAIN      = DEF_FB_GAIN,
    parameter int INIT_POS     = DEF_INIT_POS,
    parameter int INIT_NEUTRAL = DEF_INIT_NEUTRAL
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       run,
    input  logic                       cfgValid,
    output logic                       cfgReady,
    input  logic [$clog2(NUM_OSC)-1:0] cfgChannel,
    input  logic [1:0]                 cfgSel,
    input  logic [31:0]                cfgData,
    input  logic [NUM_OSC*8-1:0]       feedback,
    output logic [NUM_OSC*8-1:0]       positionOut,
    output logic                       busy,
    output logic                       sweepDone,
    output logic [15:0]                sweepCount
);

    localparam int             IW       = $clog2(NUM_OSC);
    localparam logic [IW-1:0]  LAST     = IW'(NUM_OSC - 1);
    localparam osc_word_t      RST_POS  = osc_word_t'(INIT_POS);
    localparam osc_word_t      RST_NEU  = osc_word_t'(INIT_NEUTRAL);
    localparam logic [7:0]     RST_BYTE = RST_POS[31:24];

    fsm_t                 state_q;
    fsm_t                 state_d;
    logic [IW-1:0]        idx_q;
    logic                 cfg_fire;
    logic                 last_ch;

    osc_word_t            pos_q [NUM_OSC];
    osc_word_t            vel_q [NUM_OSC];
    osc_word_t            neu_q [NUM_OSC];
    logic signed [7:0]    fb_lane [NUM_OSC];

    osc_word_t            pos_next;
    osc_word_t            vel_next;
    logic [NUM_OSC*8-1:0] snap_q;
    logic [15:0]          count_q;

    always_comb begin
        for (int i = 0; i < NUM_OSC; i++) begin
            fb_lane[i] = feedback[8*i +: 8];
        end
    end

    osc_step #(
        .KV_SHIFT (KV_SHIFT),
        .KP_SHIFT (KP_SHIFT),
        .FB_GAIN  (FB_GAIN)
    ) u_step (
        .pos      (pos_q[idx_q]),
        .vel      (vel_q[idx_q]),
        .neutral  (neu_q[idx_q]),
        .feedback (fb_lane[idx_q]),
        .pos_next (pos_next),
        .vel_next (vel_next)
    );

    // A config write in IDLE holds off any sweep request for that cycle.
    always_comb begin
        state_d  = state_q;
        cfgReady = (state_q == IDLE);
        cfg_fire = cfgValid && cfgReady;
        last_ch  = (idx_q == LAST);
        unique case (state_q)
            IDLE: begin
                if (!cfg_fire && (start || run)) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (last_ch) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SWEEP && !last_ch) begin
                idx_q <= idx_q + IW'(1);
            end else begin
                idx_q <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OSC; i++) begin
                pos_q[i] <= RST_POS;
                vel_q[i] <= '0;
                neu_q[i] <= RST_NEU;
            end
        end else begin
            for (int i = 0; i < NUM_OSC; i++) begin
                if (cfg_fire && cfgChannel == IW'(i)) begin
                    unique case (cfgSel)
                        CFG_POS:     pos_q[i] <= cfgData;
                        CFG_VEL:     vel_q[i] <= cfgData;
                        CFG_NEUTRAL: neu_q[i] <= cfgData;
                        default:     ;
                    endcase
                end else if (state_q == SWEEP && idx_q == IW'(i)) begin
                    pos_q[i] <= pos_next;
                    vel_q[i] <= vel_next;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_q  <= {NUM_OSC{RST_BYTE}};
            count_q <= '0;
        end else if (state_q == DONE) begin
            for (int i = 0; i < NUM_OSC; i++) begin
                snap_q[8*i +: 8] <= pos_byte(pos_q[i]);
            end
            count_q <= count_q + 16'd1;
        end
    end

    assign positionOut = snap_q;
    assign sweepCount  = count_q;
    assign busy        = (state_q == SWEEP) || (state_q == DONE);
    assign sweepDone   = (state_q == DONE);

endmodule

// File: tb/tb_osc_bank_scheduler.sv
// Randomized self-checking bench for osc_bank_scheduler against a
// behavioural model of the oscillator equations and sweep timing.
module tb_osc_bank_scheduler;

    localparam int N        = 4;
    localparam int INIT_POS = 429496729;
    localparam int INIT_NEU = 1073741824;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           run = 1'b0;
    logic           cfgValid = 1'b0;
    logic           cfgReady;
    logic [1:0]     cfgChannel = '0;
    logic [1:0]     cfgSel = '0;
    logic [31:0]    cfgData = '0;
    logic [N*8-1:0] feedback = '0;
    logic [N*8-1:0] positionOut;
    logic           busy;
    logic           sweepDone;
    logic [15:0]    sweepCount;

    int checks = 0;
    int errors = 0;

    int             m_pos [N];
    int             m_vel [N];
    int             m_neu [N];
    byte            fb_m [N];
    logic [N*8-1:0] m_snap;
    int             m_count;

    osc_bank_scheduler #(
        .NUM_OSC      (N),
        .KV_SHIFT     (9),
        .KP_SHIFT     (11),
        .FB_GAIN      (10000),
        .INIT_POS     (INIT_POS),
        .INIT_NEUTRAL (INIT_NEU)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .run         (run),
        .cfgValid    (cfgValid),
        .cfgReady    (cfgReady),
        .cfgChannel  (cfgChannel),
        .cfgSel      (cfgSel),
        .cfgData     (cfgData),
        .feedback    (feedback),
        .positionOut (positionOut),
        .busy        (busy),
        .sweepDone   (sweepDone),
        .sweepCount  (sweepCount)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic longint floor_div_pow2(longint x, int k);
        longint d;
        d = longint'(1) << k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int wrap32(longint x);
        return int'(x);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pos[c] = INIT_POS;
            m_vel[c] = 0;
            m_neu[c] = INIT_NEU;
            m_snap[8*c +: 8] = 8'h19;
        end
        m_count = 0;
    endtask

    task automatic model_sweep();
        for (int c = 0; c < N; c++) begin
            longint acc;
            int p;
            int v;
            p = m_pos[c];
            v = m_vel[c];
            acc = -floor_div_pow2(v, 9)
                  - floor_div_pow2(wrap32(longint'(p) - m_neu[c]), 11)
                  + longint'(fb_m[c]) * 10000;
            m_pos[c] = wrap32(longint'(p) + v);
            m_vel[c] = wrap32(longint'(v) + acc);
        end
        for (int c = 0; c < N; c++) begin
            int p;
            p = m_pos[c];
            m_snap[8*c +: 8] = p[31:24];
        end
        m_count = (m_count + 1) % 65536;
    endtask

    task automatic model_cfg(int ch, int sel, int data);
        if (sel == 0) m_pos[ch] = data;
        else if (sel == 1) m_vel[ch] = data;
        else if (sel == 2) m_neu[ch] = data;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_fb();
        for (int c = 0; c < N; c++) feedback[8*c +: 8] = fb_m[c];
    endtask

    task automatic random_fb();
        for (int c = 0; c < N; c++) fb_m[c] = byte'($urandom_range(0, 255));
        drive_fb();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        run = 1'b0;
        cfgValid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic cfg_write(input int ch, input int sel, input int data,
                             output int waited);
        cfgValid = 1'b1;
        cfgChannel = 2'(ch);
        cfgSel = 2'(sel);
        cfgData = data;
        waited = 0;
        while (!cfgReady && waited < 40) begin
            tick();
            waited++;
        end
        if (cfgReady) model_cfg(ch, sel, data);
        tick();
        cfgValid = 1'b0;
    endtask

    task automatic run_sweep(output int lat, output int bcyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        bcyc = busy ? 1 : 0;
        while (!sweepDone && lat < 40) begin
            tick();
            lat++;
            if (busy) bcyc++;
        end
        if (sweepDone) model_sweep();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < N; c++) fb_m[c] = 0;
        drive_fb();
        #1 reset = 1'b1;
        #3;
        checks++;
        if (positionOut !== 32'h19191919) begin
            errors++;
            $display("FAIL reset_async_pos: got %h expected %h", positionOut, 32'h19191919);
        end
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (positionOut !== 32'h19191919) begin
            errors++;
            $display("FAIL reset_pos: got %h expected %h", positionOut, 32'h19191919);
        end
        checks++;
        if (busy !== 1'b0 || sweepDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got busy=%b done=%b expected 0 0", busy, sweepDone);
        end
        checks++;
        if (cfgReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", cfgReady);
        end
        checks++;
        if (sweepCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", sweepCount);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.pos_q[c] !== INIT_POS || dut.vel_q[c] !== 0 || dut.neu_q[c] !== INIT_NEU) begin
                errors++;
                $display("FAIL reset_state ch%0d: got pos=%0d vel=%0d neu=%0d expected %0d 0 %0d",
                         c, dut.pos_q[c], dut.vel_q[c], dut.neu_q[c], INIT_POS, INIT_NEU);
            end
        end
    endtask

    task automatic test_single_sweep();
        int lat;
        int bc;
        for (int c = 0; c < N; c++) fb_m[c] = 0;
        drive_fb();
        run_sweep(lat, bc);
        checks++;
        if (lat != N + 1) begin
            errors++;
            $display("FAIL sweep_latency: got %0d expected %0d", lat, N + 1);
        end
        checks++;
        if (bc != N + 1) begin
            errors++;
            $display("FAIL sweep_busy_cycles: got %0d expected %0d", bc, N + 1);
        end
        checks++;
        if (busy !== 1'b0 || sweepCount !== 16'(m_count)) begin
            errors++;
            $display("FAIL sweep1_status: got busy=%b count=%0d expected 0 %0d", busy, sweepCount, m_count);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.vel_q[c] !== m_vel[c] || dut.vel_q[c] !== 314573) begin
                errors++;
                $display("FAIL sweep1_vel ch%0d: got %0d expected %0d", c, dut.vel_q[c], m_vel[c]);
            end
        end
        run_sweep(lat, bc);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.pos_q[c] !== m_pos[c] || dut.pos_q[c] !== 429811302) begin
                errors++;
                $display("FAIL sweep2_pos ch%0d: got %0d expected %0d", c, dut.pos_q[c], m_pos[c]);
            end
        end
        checks++;
        if (positionOut !== m_snap) begin
            errors++;
            $display("FAIL sweep2_snap: got %h expected %h", positionOut, m_snap);
        end
    endtask

    task automatic test_feedback();
        int w;
        int lat;
        int bc;
        random_fb();
        fb_m[1] = 8'sd1;
        drive_fb();
        cfg_write(1, 0, 1 << 30, w);
        cfg_write(1, 1, 0, w);
        run_sweep(lat, bc);
        checks++;
        if (dut.vel_q[1] !== m_vel[1] || dut.vel_q[1] !== 10000) begin
            errors++;
            $display("FAIL fb_plus1_vel: got %0d expected %0d", dut.vel_q[1], m_vel[1]);
        end
        random_fb();
        fb_m[1] = -8'sd128;
        drive_fb();
        cfg_write(1, 0, 1 << 30, w);
        cfg_write(1, 1, 0, w);
        run_sweep(lat, bc);
        checks++;
        if (dut.vel_q[1] !== m_vel[1] || dut.vel_q[1] !== -1280000) begin
            errors++;
            $display("FAIL fb_minus128_vel: got %0d expected %0d", dut.vel_q[1], m_vel[1]);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.pos_q[c] !== m_pos[c] || dut.vel_q[c] !== m_vel[c]) begin
                errors++;
                $display("FAIL fb_state ch%0d: got pos=%0d vel=%0d expected %0d %0d",
                         c, dut.pos_q[c], dut.vel_q[c], m_pos[c], m_vel[c]);
            end
        end
        checks++;
        if (positionOut !== m_snap) begin
            errors++;
            $display("FAIL fb_snap: got %h expected %h", positionOut, m_snap);
        end
    endtask

    task automatic test_wrap();
        int w;
        int lat;
        int bc;
        random_fb();
        cfg_write(2, 0, 32'h7FFFFFFF, w);
        cfg_write(2, 1, 32'h7FFFFFFF, w);
        run_sweep(lat, bc);
        checks++;
        if (dut.pos_q[2] !== 32'hFFFFFFFE || dut.pos_q[2] !== m_pos[2]) begin
            errors++;
            $display("FAIL wrap_pos: got %h expected %h", dut.pos_q[2], m_pos[2]);
        end
        checks++;
        if (positionOut[23:16] !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_snap_byte: got %h expected ff", positionOut[23:16]);
        end
        random_fb();
        run_sweep(lat, bc);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.pos_q[c] !== m_pos[c] || dut.vel_q[c] !== m_vel[c]) begin
                errors++;
                $display("FAIL wrap_state ch%0d: got pos=%h vel=%h expected %h %h",
                         c, dut.pos_q[c], dut.vel_q[c], m_pos[c], m_vel[c]);
            end
        end
        checks++;
        if (positionOut !== m_snap) begin
            errors++;
            $display("FAIL wrap_snap: got %h expected %h", positionOut, m_snap);
        end
    endtask

    task automatic test_cfg_during_sweep();
        int n;
        int ready_seen;
        int data;
        int k;
        random_fb();
        start = 1'b1;
        tick();
        start = 1'b0;
        data = int'($urandom);
        cfgValid = 1'b1;
        cfgChannel = 2'd0;
        cfgSel = 2'd1;
        cfgData = data;
        n = 0;
        ready_seen = 0;
        while (busy && n < 40) begin
            if (cfgReady) ready_seen++;
            tick();
            n++;
        end
        checks++;
        if (ready_seen != 0 || n != N + 1) begin
            errors++;
            $display("FAIL cfg_busy_ready: got ready_cycles=%0d busy_cycles=%0d expected 0 %0d",
                     ready_seen, n, N + 1);
        end
        checks++;
        if (cfgReady !== 1'b1) begin
            errors++;
            $display("FAIL cfg_idle_ready: got %b expected 1", cfgReady);
        end
        model_sweep();
        model_cfg(0, 1, data);
        tick();
        cfgValid = 1'b0;
        checks++;
        if (dut.vel_q[0] !== m_vel[0] || positionOut !== m_snap) begin
            errors++;
            $display("FAIL cfg_after_sweep: got vel=%0d snap=%h expected %0d %h",
                     dut.vel_q[0], positionOut, m_vel[0], m_snap);
        end
        data = int'($urandom);
        cfgValid = 1'b1;
        cfgChannel = 2'd3;
        cfgSel = 2'd0;
        cfgData = data;
        start = 1'b1;
        tick();
        model_cfg(3, 0, data);
        checks++;
        if (busy !== 1'b0 || dut.pos_q[3] !== m_pos[3]) begin
            errors++;
            $display("FAIL cfg_wins: got busy=%b pos3=%h expected 0 %h", busy, dut.pos_q[3], m_pos[3]);
        end
        cfgValid = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg_then_sweep: got busy=%b expected 1", busy);
        end
        k = 0;
        while (!sweepDone && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (sweepDone !== 1'b1) begin
            errors++;
            $display("FAIL cfg_sweep_timeout: got %b expected 1", sweepDone);
        end
        model_sweep();
        tick();
        checks++;
        if (positionOut !== m_snap || sweepCount !== 16'(m_count)) begin
            errors++;
            $display("FAIL cfg_sweep_snap: got %h/%0d expected %h/%0d",
                     positionOut, sweepCount, m_snap, m_count);
        end
    endtask

    task automatic test_run();
        int t;
        int np;
        int stamp [3];
        int pulses;
        apply_reset();
        random_fb();
        run = 1'b1;
        t = 0;
        np = 0;
        while (np < 3 && t < 100) begin
            tick();
            t++;
            if (sweepDone) begin
                stamp[np] = t;
                np++;
                model_sweep();
                if (np == 3) run = 1'b0;
            end
        end
        run = 1'b0;
        checks++;
        if (np != 3) begin
            errors++;
            $display("FAIL run_pulses: got %0d expected 3", np);
        end else begin
            checks++;
            if (stamp[0] != N + 1 || stamp[1] - stamp[0] != N + 2 || stamp[2] - stamp[1] != N + 2) begin
                errors++;
                $display("FAIL run_spacing: got %0d,%0d,%0d expected %0d then +%0d",
                         stamp[0], stamp[1], stamp[2], N + 1, N + 2);
            end
        end
        tick();
        checks++;
        if (sweepCount !== 16'd3 || sweepCount !== 16'(m_count)) begin
            errors++;
            $display("FAIL run_count: got %0d expected %0d", sweepCount, m_count);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || positionOut !== m_snap) begin
            errors++;
            $display("FAIL run_stop: got busy=%b snap=%h expected 0 %h", busy, positionOut, m_snap);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.pos_q[c] !== m_pos[c] || dut.vel_q[c] !== m_vel[c]) begin
                errors++;
                $display("FAIL run_state ch%0d: got pos=%0d vel=%0d expected %0d %0d",
                         c, dut.pos_q[c], dut.vel_q[c], m_pos[c], m_vel[c]);
            end
        end
        run = 1'b1;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        run = 1'b0;
        model_reset();
        checks++;
        if (busy !== 1'b0 || sweepDone !== 1'b0 || sweepCount !== 16'd0 || cfgReady !== 1'b1) begin
            errors++;
            $display("FAIL midreset_status: got busy=%b done=%b count=%0d ready=%b expected 0 0 0 1",
                     busy, sweepDone, sweepCount, cfgReady);
        end
        checks++;
        if (positionOut !== m_snap) begin
            errors++;
            $display("FAIL midreset_snap: got %h expected %h", positionOut, m_snap);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut.pos_q[c] !== m_pos[c] || dut.vel_q[c] !== m_vel[c]) begin
                errors++;
                $display("FAIL midreset_state ch%0d: got pos=%0d vel=%0d expected %0d %0d",
                         c, dut.pos_q[c], dut.vel_q[c], m_pos[c], m_vel[c]);
            end
        end
        pulses = 0;
        repeat (3) begin
            tick();
            if (sweepDone) pulses++;
        end
        reset = 1'b0;
        tick();
        if (sweepDone) pulses++;
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: got pulses=%0d busy=%b expected 0 0", pulses, busy);
        end
    endtask

    task automatic test_random();
        int w;
        int lat;
        int bc;
        int nw;
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) begin
                cfg_write($urandom_range(0, N - 1), $urandom_range(0, 3), int'($urandom), w);
            end
            random_fb();
            run_sweep(lat, bc);
            checks++;
            if (lat != N + 1) begin
                errors++;
                $display("FAIL rand_latency it%0d: got %0d expected %0d", it, lat, N + 1);
            end
            checks++;
            if (positionOut !== m_snap || sweepCount !== 16'(m_count)) begin
                errors++;
                $display("FAIL rand_snap it%0d: got %h/%0d expected %h/%0d",
                         it, positionOut, sweepCount, m_snap, m_count);
            end
            for (int c = 0; c < N; c++) begin
                checks++;
                if (dut.pos_q[c] !== m_pos[c] || dut.vel_q[c] !== m_vel[c] || dut.neu_q[c] !== m_neu[c]) begin
                    errors++;
                    $display("FAIL rand_state it%0d ch%0d: got %h %h %h expected %h %h %h",
                             it, c, dut.pos_q[c], dut.vel_q[c], dut.neu_q[c],
                             m_pos[c], m_vel[c], m_neu[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_feedback();
        test_wrap();
        test_cfg_during_sweep();
        test_random();
        test_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
